// File: rtl/exception_unit_table_pkg.sv
// exception_unit_table_pkg: shared sizes, ID/unit types, named exception sources and sweep FSM states
package exception_unit_table_pkg;
    localparam int MAX_IDS = 8;
    localparam int NUM_EXCEPTION_SOURCES = 3;
    localparam int IDW = $clog2(MAX_IDS);
    localparam int UW = $clog2(NUM_EXCEPTION_SOURCES);
    typedef logic [IDW-1:0] id_t;
    typedef logic [UW-1:0] exception_unit_t;
    localparam exception_unit_t LS = exception_unit_t'(0);
    localparam exception_unit_t BRANCH = exception_unit_t'(1);
    localparam exception_unit_t GC = exception_unit_t'(2);
    typedef enum logic [1:0] {IDLE, SWEEP, DONE} sweep_state_t;
endpackage

// File: rtl/exception_unit_table_if.sv
// exception_unit_table_if: issue/retire/lookup/clear signals between global control + issue (master) and the table (slave)
//   init_clear/init_done        sweep request and completion
//   issue_*                     issue-time write of the target unit
//   retire_*                    retire-time invalidation
//   lookup_id_next              next oldest ID, answered one cycle later on current_exception_unit(_valid)
interface exception_unit_table_if;
    import exception_unit_table_pkg::*;
    logic init_clear;
    logic init_done;
    logic issue_valid;
    logic issue_may_except;
    id_t issue_id;
    exception_unit_t issue_unit;
    logic retire_valid;
    id_t retire_id;
    id_t lookup_id_next;
    exception_unit_t current_exception_unit;
    logic current_exception_unit_valid;
    modport master(
        output init_clear, issue_valid, issue_may_except, issue_id, issue_unit,
               retire_valid, retire_id, lookup_id_next,
        input init_done, current_exception_unit, current_exception_unit_valid
    );
    modport slave(
        input init_clear, issue_valid, issue_may_except, issue_id, issue_unit,
              retire_valid, retire_id, lookup_id_next,
        output init_done, current_exception_unit, current_exception_unit_valid
    );
endinterface

// File: rtl/exception_unit_table_id_lutram_1w1r.sv
// id_lutram_1w1r: DEPTH x WIDTH array, one synchronous write port, one asynchronous read port
//   clk, we/waddr/wdata write port, raddr/rdata combinational read port
module id_lutram_1w1r #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/exception_unit_table.sv
// exception_unit_table: per-ID record of the exception unit each issued instruction went to, read out for the oldest ID
//   clk, rst (sync, active-high), bus (exception_unit_table_if.slave)
//   Optional EXCEPTION_UNIT_VALID_EN: builds per-entry valid bits and the retire clear path;
//   otherwise current_exception_unit_valid is 1 outside reset and sweep.
module exception_unit_table
    import exception_unit_table_pkg::*;
(
    input logic clk,
    input logic rst,
    exception_unit_table_if.slave bus
);
    sweep_state_t state;
    logic [IDW:0] sweep_idx;
    logic init_done_q;
    logic sweeping;
    logic issue_wr;
    logic mem_we;
    logic hold_zero;
    logic bypass;
    logic ev_rd;
    logic valid_q;
    id_t mem_waddr;
    exception_unit_t mem_wdata;
    exception_unit_t mem_rdata;
    exception_unit_t unit_q;

    // The sweep shares the single write port and always wins over issue.
    assign sweeping = state == SWEEP;
    assign issue_wr = bus.issue_valid & bus.issue_may_except & ~sweeping;
    assign mem_we = sweeping | issue_wr;
    assign mem_waddr = sweeping ? sweep_idx[IDW-1:0] : bus.issue_id;
    assign mem_wdata = sweeping ? '0 : bus.issue_unit;
    assign bypass = mem_we && mem_waddr == bus.lookup_id_next;
    // Outputs are forced to zero for every cycle spent in SWEEP, so clear them on the edge into each such cycle.
    assign hold_zero = (state == IDLE && bus.init_clear) ||
                       (sweeping && sweep_idx != (IDW+1)'(MAX_IDS-1));

    id_lutram_1w1r #(.DEPTH(MAX_IDS), .WIDTH(UW)) u_mem (
        .clk(clk),
        .we(mem_we),
        .waddr(mem_waddr),
        .wdata(mem_wdata),
        .raddr(bus.lookup_id_next),
        .rdata(mem_rdata)
    );

`ifdef EXCEPTION_UNIT_VALID_EN
    logic [MAX_IDS-1:0] entry_valid;

    // Retire clear first, issue set second: a same-cycle reissue of the retiring ID stays valid.
    always_ff @(posedge clk) begin
        if (rst) entry_valid <= '0;
        else if (sweeping) entry_valid[sweep_idx[IDW-1:0]] <= 1'b0;
        else begin
            if (bus.retire_valid) entry_valid[bus.retire_id] <= 1'b0;
            if (issue_wr) entry_valid[bus.issue_id] <= 1'b1;
        end
    end

    assign ev_rd = entry_valid[bus.lookup_id_next];
`else
    logic unused_retire;
    assign unused_retire = ^{bus.retire_valid, bus.retire_id};
    assign ev_rd = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst || hold_zero) begin
            unit_q <= '0;
            valid_q <= 1'b0;
        end else begin
            unit_q <= bypass ? mem_wdata : mem_rdata;
            valid_q <= bypass ? ~sweeping : ev_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sweep_idx <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.init_clear) begin
                    state <= SWEEP;
                    sweep_idx <= '0;
                    init_done_q <= 1'b0;
                end
                SWEEP: begin
                    sweep_idx <= sweep_idx + 1'b1;
                    if (sweep_idx == (IDW+1)'(MAX_IDS-1)) begin
                        state <= DONE;
                        init_done_q <= 1'b1;
                    end
                end
                DONE: if (!bus.init_clear) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.init_done = init_done_q;
    assign bus.current_exception_unit = unit_q;
    assign bus.current_exception_unit_valid = valid_q;
endmodule

// File: tb/tb_exception_unit_table.sv
// tb_exception_unit_table: directed self-checking bench for exception_unit_table
module tb_exception_unit_table;
    import exception_unit_table_pkg::*;

`ifdef EXCEPTION_UNIT_VALID_EN
    localparam bit VEN = 1'b1;
`else
    localparam bit VEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int failed = 0;
    int cnt;

    exception_unit_table_if bus();

    exception_unit_table dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag);
        cnt = 0;
        while (!bus.init_done && cnt < 20) begin
            step();
            cnt++;
        end
        check(tag, cnt, 8);
    endtask

    initial begin
        bus.init_clear = 0;
        bus.issue_valid = 0;
        bus.issue_may_except = 0;
        bus.issue_id = '0;
        bus.issue_unit = '0;
        bus.retire_valid = 0;
        bus.retire_id = '0;
        bus.lookup_id_next = '0;
        step();
        step();
        check("rst_init_done", bus.init_done, 0);
        check("rst_unit", bus.current_exception_unit, 0);
        check("rst_valid", bus.current_exception_unit_valid, 0);
        rst = 0;
        bus.init_clear = 1;
        step();
        check("sweep_entry_done", bus.init_done, 0);
        check("sweep_valid0", bus.current_exception_unit_valid, 0);
        wait_done("sweep_len");
        check("sweep_unit0", bus.current_exception_unit, 0);
        bus.init_clear = 0;
        step();
        check("idle_done_held", bus.init_done, 1);
        for (int i = 0; i < 8; i++) begin
            bus.lookup_id_next = id_t'(i);
            step();
            check($sformatf("clr_unit%0d", i), bus.current_exception_unit, 0);
            check($sformatf("clr_valid%0d", i), bus.current_exception_unit_valid, VEN ? 0 : 1);
        end
        bus.issue_valid = 1;
        bus.issue_may_except = 1;
        bus.issue_id = 3;
        bus.issue_unit = GC;
        bus.lookup_id_next = 3;
        step();
        check("bypass_unit", bus.current_exception_unit, 2);
        check("bypass_valid", bus.current_exception_unit_valid, 1);
        bus.lookup_id_next = 0;
        for (int i = 0; i < 8; i++) begin
            bus.issue_id = id_t'(i);
            bus.issue_unit = exception_unit_t'(i % 3);
            step();
        end
        bus.issue_valid = 0;
        for (int i = 7; i >= 0; i--) begin
            bus.lookup_id_next = id_t'(i);
            step();
            check($sformatf("rev_unit%0d", i), bus.current_exception_unit, i % 3);
            check($sformatf("rev_valid%0d", i), bus.current_exception_unit_valid, 1);
        end
        bus.issue_valid = 1;
        bus.issue_may_except = 0;
        bus.issue_id = 2;
        bus.issue_unit = LS;
        bus.lookup_id_next = 2;
        step();
        check("noexc_same_cycle", bus.current_exception_unit, 2);
        bus.issue_valid = 0;
        step();
        check("noexc_unit", bus.current_exception_unit, 2);
        check("noexc_valid", bus.current_exception_unit_valid, 1);
        if (VEN) begin
            bus.issue_valid = 1;
            bus.issue_may_except = 1;
            bus.issue_id = 5;
            bus.issue_unit = BRANCH;
            bus.retire_valid = 1;
            bus.retire_id = 5;
            bus.lookup_id_next = 0;
            step();
            bus.issue_valid = 0;
            bus.retire_valid = 0;
            bus.lookup_id_next = 5;
            step();
            check("reissue_unit", bus.current_exception_unit, 1);
            check("reissue_valid", bus.current_exception_unit_valid, 1);
            bus.retire_valid = 1;
            bus.lookup_id_next = 0;
            step();
            bus.retire_valid = 0;
            bus.lookup_id_next = 5;
            step();
            check("retire_valid", bus.current_exception_unit_valid, 0);
            check("retire_unit", bus.current_exception_unit, 1);
        end
        bus.init_clear = 1;
        step();
        check("resweep_entry_done", bus.init_done, 0);
        for (int i = 0; i < 4; i++) step();
        check("mid_sweep_done", bus.init_done, 0);
        rst = 1;
        bus.init_clear = 0;
        step();
        check("mid_rst_done", bus.init_done, 0);
        check("mid_rst_unit", bus.current_exception_unit, 0);
        rst = 0;
        for (int i = 0; i < 3; i++) step();
        check("post_rst_idle_done", bus.init_done, 0);
        bus.init_clear = 1;
        step();
        wait_done("resweep_len");
        bus.init_clear = 0;
        bus.lookup_id_next = 3;
        step();
        check("resweep_unit3", bus.current_exception_unit, 0);
        check("resweep_valid3", bus.current_exception_unit_valid, VEN ? 0 : 1);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/exception_unit_table.md
# exception_unit_table

Per-ID lookup table that records which exception-capable unit each issued instruction was dispatched to. It supplies the unit index of the oldest in-flight instruction to the global control unit, so that unit needs to compare only one exception source against the oldest ID instead of all of them. It sits between issue and global control. Writes happen at issue, reads are driven by the next-oldest retire ID, and the table is swept clean during the global-control initial clear.

## Interface
Parameters:
- MAX_IDS, 8, number of in-flight instruction IDs; power of two, at least 2.
- NUM_EXCEPTION_SOURCES, 3, number of exception-capable units; at least 2.
- Derived: IDW = log2(MAX_IDS); UW = log2(NUM_EXCEPTION_SOURCES).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- init_clear  in  1  global-control initial clear request, level
- init_done  out  1  table sweep complete
- issue_valid  in  1  instruction issued this cycle
- issue_may_except  in  1  issued instruction targets an exception-capable unit
- issue_id  in  IDW  ID of the issued instruction
- issue_unit  in  UW  exception source index of the target unit
- retire_valid  in  1  oldest instruction retires this cycle
- retire_id  in  IDW  ID of the retiring instruction
- lookup_id_next  in  IDW  ID that will be oldest next cycle
- current_exception_unit  out  UW  unit index for the current oldest ID
- current_exception_unit_valid  out  1  entry was written since the last clear or retire

## Operation
- Storage: an MAX_IDS × UW array, `unit_mem`. With EXCEPTION_UNIT_VALID_EN defined, an MAX_IDS-bit `entry_valid` vector is added.
- Write: when issue_valid & issue_may_except & ~sweeping, `unit_mem[issue_id] <= issue_unit` and `entry_valid[issue_id] <= 1`.
- Retire: when retire_valid, `entry_valid[retire_id] <= 0`. If the same cycle also writes the same ID, the set wins.
- Lookup: `current_exception_unit <= unit_mem[lookup_id_next]`, registered.
  - Write-bypass: if the same cycle writes lookup_id_next, the register takes issue_unit instead.
  - The valid output is registered the same way, with the same bypass.
- Sweep state machine, states IDLE, SWEEP, DONE:
  - IDLE → SWEEP when init_clear is high.
  - SWEEP: a counter `sweep_idx` (IDW+1 bits) writes 0 to `unit_mem[sweep_idx]` and clears `entry_valid[sweep_idx]` each cycle.
  - SWEEP → DONE when `sweep_idx == MAX_IDS-1`.
  - DONE → IDLE when init_clear is low. DONE → SWEEP again if init_clear is re-raised after a visit to IDLE.
- init_done is high in DONE and in IDLE after the first completed sweep. It is cleared by rst or by entering SWEEP.
- Issue writes are ignored while in SWEEP; the sweep has priority. Retire clears are also ignored in SWEEP.
- IDs wrap modulo MAX_IDS. The table does not check for overwriting a live entry; the ID allocator guarantees uniqueness.

## Timing
- Reset values:
  - state IDLE, sweep_idx 0, init_done 0.
  - current_exception_unit 0, current_exception_unit_valid 0.
  - Array contents are undefined until the first sweep completes.
- Lookup latency is 1 cycle. A lookup_id_next presented in cycle N appears on current_exception_unit in cycle N+1, aligned with that ID becoming oldest.
- Issue-to-visible latency is 1 cycle (bypass). An instruction issued in cycle N is readable in cycle N+1 for any ID.
- Sweep length is exactly MAX_IDS cycles from entering SWEEP. init_done rises in the cycle after the last write.
- rst asserted mid-sweep returns the block to IDLE with init_done 0. Global control must re-issue init_clear.
- During SWEEP, current_exception_unit reads 0 and current_exception_unit_valid reads 0.

## Configuration
- EXCEPTION_UNIT_VALID_EN defined: the `entry_valid` vector and the retire clear path are built. current_exception_unit_valid reflects the entry state.
- Not defined: `entry_valid` is removed, retire_valid and retire_id are unused, and current_exception_unit_valid is tied to 1 after reset deasserts. It is still 0 during rst and SWEEP.

## Structure
- Shared package: MAX_IDS, the id_t typedef, NUM_EXCEPTION_SOURCES, and an `exception_unit_t` typedef (UW bits) with named source indices (LS, BRANCH, GC).
- Sub-module: `id_lutram_1w1r`, a single-write, single-async-read array with parameters DEPTH and WIDTH. The registered read, bypass and sweep logic stay in exception_unit_table.

## Test plan
- Reset, then init_clear held → init_done rises exactly 8 cycles after SWEEP entry (MAX_IDS=8); lookups of all IDs then return unit 0, valid 0.
- Issue id 3 with unit 2 in cycle N, lookup_id_next=3 in cycle N → output unit 2, valid 1 in cycle N+1 (bypass).
- Issue ids 0..7 with units 0,1,2,0,1,2,0,1, then look up in reverse order → each returns its unit 1 cycle after its lookup.
- Macro on: retire id 5 and reissue id 5 (unit 1) in the same cycle → entry valid, unit 1. Retire id 5 alone → next lookup of 5 gives valid 0.
- Issue with issue_may_except=0 for id 2 → prior contents of id 2 are unchanged.
- rst asserted at sweep cycle 4 → state IDLE, init_done 0. A new init_clear sweeps the full 8 cycles.
